// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - end-around-carry adder and rotating-priority helpers
package mod_arith_pkg;

   localparam int MAX_W   = 64;
   localparam int MAX_REQ = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } res_state_e;

   // Operands are below 2**width, so folding the carry back in can never carry again.
   function automatic logic [MAX_W-1:0] mod_add(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input int               width);
      logic [MAX_W:0]   s;
      logic [MAX_W-1:0] mask;
      s    = {1'b0, a} + {1'b0, b};
      mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
      return (s[MAX_W-1:0] & mask) + MAX_W'(s[width]);
   endfunction

   // First set bit of req scanning from ptr upward, wrapping at nreq.
   function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [3:0]         ptr,
                                          input int                 nreq);
      logic [3:0] pick;
      int         j;
      pick = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < nreq) begin
            j = int'(ptr) + k;
            if (j >= nreq) j = j - nreq;
            if (req[j[3:0]]) pick = j[3:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NREQ-1:0] req_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_idx_o,
   output logic            gnt_valid_o
);
   import mod_arith_pkg::*;

   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;

   assign gnt_idx_o   = IDW'(rr_pick(MAX_REQ'(req_i), 4'(ptr_q), NREQ));
   assign gnt_valid_o = en_i && !rst_i && (|req_i);
   assign gnt_o       = gnt_valid_o ? (NREQ'(1) << gnt_idx_o) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_valid_o) begin
         ptr_d = (gnt_idx_o == IDW'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mod_adder_arbiter.sv
// rtl/mod_adder_arbiter.sv - shared one's-complement adder with round-robin request arbitration
module mod_adder_arbiter #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*WIDTH-1:0] req_a_i,
   input  logic [NREQ*WIDTH-1:0] req_b_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [WIDTH-1:0]      res_data_o,
   output logic [IDW-1:0]        res_id_o
);
   import mod_arith_pkg::*;

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_valid;
   logic             can_accept;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] sum;

   res_state_e       state_q, state_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [IDW-1:0]   res_id_q, res_id_d;

   assign can_accept = (state_q == ST_EMPTY) || res_ready_i;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_valid_i),
      .en_i        (can_accept),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   assign req_ready_o = gnt;
   assign a_sel       = req_a_i[gnt_idx*WIDTH +: WIDTH];
   assign b_sel       = req_b_i[gnt_idx*WIDTH +: WIDTH];
   assign sum         = WIDTH'(mod_add(MAX_W'(a_sel), MAX_W'(b_sel), WIDTH));

   // A grant on a draining edge overwrites the register directly, so there is no bubble.
   always_comb begin
      state_d    = state_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      if (gnt_valid) begin
         state_d    = ST_FULL;
         res_data_d = sum;
         res_id_d   = gnt_idx;
      end else if (state_q == ST_FULL && res_ready_i) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_EMPTY;
         res_data_q <= '0;
         res_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
      end
   end

   assign res_valid_o = (state_q == ST_FULL);
   assign res_data_o  = res_data_q;
   assign res_id_o    = res_id_q;

endmodule
